hazard_controller: RTL and testbench

- Central pipeline sequencer for the 16-bit, 5-stage core. Drives stall, flush and freeze controls into the fetch, decode, execute and memory pipeline registers.
- Computes the execute-stage operand forwarding selects.
- Handles load-use stalls, taken-branch flushes, multi-cycle data-memory waits with a watchdog, and a drain-then-halt debug sequence.

---
 rtl/hazard_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_hazard_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: forwarding selects, load-use/branch/memory-wait control and debug drain/halt.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int R0_IS_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rs1_d,
  input  logic [2:0]  rs2_d,
  input  logic        uses_rs1_d,
  input  logic        uses_rs2_d,
  input  logic [2:0]  rs1_e,
  input  logic [2:0]  rs2_e,
  input  logic [2:0]  rd_e,
  input  logic        write_reg_e,
  input  logic        load_e,
  input  logic        branch_taken_e,
  input  logic [2:0]  rd_m,
  input  logic        write_reg_m,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  input  logic [2:0]  rd_w,
  input  logic        write_reg_w,
  input  logic        halt_req,
  input  logic        resume,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        freeze,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALT} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic          halt_pend_q, halt_pend_d;
  logic          mem_err_q, mem_err_d;
  logic          from_drain_q, from_drain_d;
  logic          mem_stall, load_use, flush_cause;

  function automatic logic reg_match(input logic [2:0] a, input logic [2:0] b);
    return (a == b) && !((R0_IS_ZERO != 0) && (a == 3'd0));
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (write_reg_m && reg_match(rd_m, rs1_e))      fwd_a = 2'b10;
    else if (write_reg_w && reg_match(rd_w, rs1_e)) fwd_a = 2'b01;
    if (write_reg_m && reg_match(rd_m, rs2_e))      fwd_b = 2'b10;
    else if (write_reg_w && reg_match(rd_w, rs2_e)) fwd_b = 2'b01;
  end

  assign mem_stall = mem_req_m && !mem_ready;
  assign load_use  = load_e && write_reg_e &&
                     ((uses_rs1_d && reg_match(rd_e, rs1_d)) ||
                      (uses_rs2_d && reg_match(rd_e, rs2_d)));

  // Pipeline control outputs; a memory stall freezes everything except in HALT
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    freeze      = 1'b0;
    flush_cause = 1'b0;
    if (!rst) begin
      if (mem_stall && state_q != HALT) begin
        freeze  = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
      end else if (state_q == HALT) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (state_q == DRAIN) begin
        stall_f     = 1'b1;
        stall_d     = 1'b1;
        flush_e     = 1'b1;
        flush_d     = branch_taken_e;
        flush_cause = branch_taken_e;
      end else if (branch_taken_e) begin
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        flush_cause = 1'b1;
      end else if (load_use) begin
        stall_f     = 1'b1;
        stall_d     = 1'b1;
        flush_e     = 1'b1;
        flush_cause = 1'b1;
      end
    end
  end

  assign halted  = !rst && (state_q == HALT);
  assign mem_err = mem_err_q;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    halt_pend_d  = halt_pend_q;
    mem_err_d    = mem_err_q;
    from_drain_d = from_drain_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d      = MEM_WAIT;
          from_drain_d = 1'b0;
          wait_cnt_d   = '0;
          if (halt_req) halt_pend_d = 1'b1;
        end else if (halt_req || halt_pend_q) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
          halt_pend_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (!mem_stall) begin
          wait_cnt_d = '0;
          if (from_drain_q) begin
            state_d     = DRAIN;
            halt_pend_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HALT;
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      // Frozen drain cycles do not count as injected bubbles
      DRAIN: begin
        if (mem_stall) begin
          state_d      = MEM_WAIT;
          from_drain_d = 1'b1;
          wait_cnt_d   = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = HALT;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      HALT: begin
        if (resume) begin
          state_d     = RUN;
          mem_err_d   = 1'b0;
          halt_pend_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      drain_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      halt_pend_q  <= 1'b0;
      mem_err_q    <= 1'b0;
      from_drain_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      halt_pend_q  <= halt_pend_d;
      mem_err_q    <= mem_err_d;
      from_drain_q <= from_drain_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall_f && (state_q == RUN || state_q == MEM_WAIT) && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush_cause && flush_cycles_q != 16'hFFFF)
      flush_cycles_d = flush_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`else
  assign stall_cycles = 16'h0000;
  assign flush_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each cycle's expected control vector is queued as
// stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        uses_rs1_d, uses_rs2_d, write_reg_e, load_e, branch_taken_e;
  logic        write_reg_m, mem_req_m, mem_ready, write_reg_w, halt_req, resume;
  logic        stall_f, stall_d, flush_d, flush_e, freeze, halted, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles, flush_cycles;

  int n_vec  = 0;
  int n_miss = 0;
  logic [10:0] exp_q[$];

  hazard_controller dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .write_reg_e(write_reg_e), .load_e(load_e),
    .branch_taken_e(branch_taken_e), .rd_m(rd_m), .write_reg_m(write_reg_m),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready), .rd_w(rd_w), .write_reg_w(write_reg_w),
    .halt_req(halt_req), .resume(resume),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout got=running want=finished");
    $fatal(1, "[TB] simulation time limit expired");
  end

  function automatic logic [10:0] ev(input bit sf, input bit sd, input bit fd, input bit fe,
                                     input bit fz, input bit h, input bit me,
                                     input logic [1:0] fa, input logic [1:0] fb);
    return {sf, sd, fd, fe, fz, h, me, fa, fb};
  endfunction

  function automatic logic [10:0] obs();
    return {stall_f, stall_d, flush_d, flush_e, freeze, halted, mem_err, fwd_a, fwd_b};
  endfunction

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    uses_rs1_d = 0; uses_rs2_d = 0; write_reg_e = 0; load_e = 0; branch_taken_e = 0;
    write_reg_m = 0; mem_req_m = 0; mem_ready = 0; write_reg_w = 0; halt_req = 0; resume = 0;
  endtask

  task automatic load_use_rs1();
    load_e = 1; write_reg_e = 1; rd_e = 3; rs1_d = 3; uses_rs1_d = 1;
  endtask

  localparam logic [10:0] ZERO   = 11'b0;
  localparam logic [10:0] FRZ    = 11'b11001_00_0000;
  localparam logic [10:0] LUSE   = 11'b11010_00_0000;
  localparam logic [10:0] BRF    = 11'b00110_00_0000;
  localparam logic [10:0] DRN    = 11'b11010_00_0000;
  localparam logic [10:0] HLT    = 11'b11010_10_0000;

  task automatic test_reset();
    logic [10:0] got, want;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; idle();
      if (c < 2) begin
        rst = 1; mem_req_m = 1; branch_taken_e = 1; load_use_rs1(); halt_req = 1;
      end else begin
        rst = 0;
      end
      exp_q.push_back(ZERO);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL reset cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    logic [10:0] got, want;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin load_use_rs1(); exp_q.push_back(LUSE); end
        1: begin write_reg_m = 1; rd_m = 3; rs1_e = 3; exp_q.push_back(ev(0,0,0,0,0,0,0,2'b10,2'b00)); end
        2: begin load_e = 1; write_reg_e = 1; rd_e = 4; rs2_d = 4; uses_rs2_d = 1; exp_q.push_back(LUSE); end
        3: begin load_e = 1; write_reg_e = 1; rd_e = 4; rs2_d = 4; uses_rs2_d = 0; exp_q.push_back(ZERO); end
        4: begin load_e = 1; write_reg_e = 1; rd_e = 0; rs1_d = 0; uses_rs1_d = 1; exp_q.push_back(ZERO); end
        default: begin load_use_rs1(); write_reg_e = 0; exp_q.push_back(ZERO); end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL load_use cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_forward();
    logic [10:0] got, want;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin write_reg_m = 1; rd_m = 5; write_reg_w = 1; rd_w = 5; rs2_e = 5;
                 exp_q.push_back(ev(0,0,0,0,0,0,0,2'b00,2'b10)); end
        1: begin write_reg_w = 1; rd_m = 5; rd_w = 5; rs2_e = 5;
                 exp_q.push_back(ev(0,0,0,0,0,0,0,2'b00,2'b01)); end
        2: begin write_reg_m = 1; write_reg_w = 1; exp_q.push_back(ZERO); end
        3: begin write_reg_m = 1; rd_m = 2; write_reg_w = 1; rd_w = 6; rs1_e = 6; rs2_e = 2;
                 exp_q.push_back(ev(0,0,0,0,0,0,0,2'b01,2'b10)); end
        default: begin write_reg_m = 1; rd_m = 2; write_reg_w = 1; rd_w = 6; rs1_e = 7; rs2_e = 1;
                 exp_q.push_back(ZERO); end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL forward cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_branch();
    logic [10:0] got, want;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin load_use_rs1(); branch_taken_e = 1; exp_q.push_back(BRF); end
        1: begin branch_taken_e = 1; exp_q.push_back(BRF); end
        default: exp_q.push_back(ZERO);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL branch cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [10:0] got, want;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1; idle();
      if (c < 4) begin
        mem_req_m = 1;
        if (c == 1) begin load_use_rs1(); branch_taken_e = 1; end
        exp_q.push_back(FRZ);
      end else if (c == 4) begin
        mem_req_m = 1; mem_ready = 1; exp_q.push_back(ZERO);
      end else if (c == 5) begin
        load_use_rs1(); exp_q.push_back(LUSE);
      end else begin
        exp_q.push_back(ZERO);
      end
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL mem_wait cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_watchdog(input bit use_reset);
    logic [10:0] got, want;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1; idle();
      if (c <= 16) begin
        mem_req_m = 1; exp_q.push_back(FRZ);
      end else if (c == 17) begin
        mem_req_m = 1; exp_q.push_back(ev(1,1,0,1,0,1,1,2'b00,2'b00));
      end else if (c == 18) begin
        if (use_reset) begin
          rst = 1; exp_q.push_back(ev(0,0,0,0,0,0,1,2'b00,2'b00));
        end else begin
          resume = 1; exp_q.push_back(ev(1,1,0,1,0,1,1,2'b00,2'b00));
        end
      end else begin
        rst = 0; exp_q.push_back(ZERO);
      end
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL watchdog rst=%0d cyc%0d got=%b want=%b", use_reset, c, got, want);
      end
    end
  endtask

  task automatic test_halt();
    logic [10:0] got, want;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin halt_req = 1; exp_q.push_back(ZERO); end
        1, 3: exp_q.push_back(DRN);
        2: begin branch_taken_e = 1; exp_q.push_back(11'b11110_00_0000); end
        4: begin halt_req = 1; exp_q.push_back(HLT); end
        5: begin halt_req = 1; branch_taken_e = 1; exp_q.push_back(HLT); end
        6: begin halt_req = 1; resume = 1; exp_q.push_back(HLT); end
        default: exp_q.push_back(ZERO);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL halt cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_halt_in_mem_wait();
    logic [10:0] got, want;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin mem_req_m = 1; exp_q.push_back(FRZ); end
        1: begin mem_req_m = 1; halt_req = 1; exp_q.push_back(FRZ); end
        2: begin mem_req_m = 1; mem_ready = 1; exp_q.push_back(ZERO); end
        3: exp_q.push_back(ZERO);
        4, 5, 6: exp_q.push_back(DRN);
        7: exp_q.push_back(HLT);
        8: begin resume = 1; exp_q.push_back(HLT); end
        default: exp_q.push_back(ZERO);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL halt_in_mem_wait cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_mem_wait_in_drain();
    logic [10:0] got, want;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin halt_req = 1; exp_q.push_back(ZERO); end
        1, 5, 6: exp_q.push_back(DRN);
        2, 3: begin mem_req_m = 1; exp_q.push_back(FRZ); end
        4: begin mem_req_m = 1; mem_ready = 1; exp_q.push_back(ZERO); end
        7: exp_q.push_back(HLT);
        8: begin resume = 1; exp_q.push_back(HLT); end
        default: exp_q.push_back(ZERO);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL mem_wait_in_drain cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [10:0] got, want;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0, 1, 2, 3, 4: begin mem_req_m = 1; exp_q.push_back(FRZ); end
        5: begin rst = 1; mem_req_m = 1; exp_q.push_back(ZERO); end
        6: begin rst = 0; exp_q.push_back(ZERO); end
        7: begin halt_req = 1; exp_q.push_back(ZERO); end
        8, 9, 10: exp_q.push_back(DRN);
        11: exp_q.push_back(HLT);
        12: begin rst = 1; exp_q.push_back(ZERO); end
        default: begin rst = 0; load_use_rs1(); exp_q.push_back(LUSE); end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("[TB] FAIL reset_mid_wait cyc%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF_N = 70000;
    localparam logic [15:0] PERF_EXP = 16'hFFFF;
`else
    localparam int PERF_N = 40;
    localparam logic [15:0] PERF_EXP = 16'h0000;
`endif
    @(posedge clk); #1; idle(); rst = 1;
    @(posedge clk); #1; rst = 0;
    for (int c = 0; c < PERF_N; c++) begin
      idle(); load_use_rs1();
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    n_vec++;
    if (stall_cycles !== PERF_EXP) begin
      n_miss++; $display("[TB] FAIL perf_stall got=%h want=%h", stall_cycles, PERF_EXP);
    end
    n_vec++;
    if (flush_cycles !== PERF_EXP) begin
      n_miss++; $display("[TB] FAIL perf_flush got=%h want=%h", flush_cycles, PERF_EXP);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_halt();
    test_halt_in_mem_wait();
    test_mem_wait_in_drain();
    test_reset_mid_wait();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
